// File: rtl/mux_pkg.sv
// Shared types and constants for the registered operand multiplexer.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [31:0] DEFAULT_CONST_VAL = 32'd4;

endpackage

// File: rtl/mux_sel_core.sv
// Combinational channel select with optional constant slot and out-of-range detect.
// Optional feature macro: MUX_CONST_EN (replaces channel CONST_IDX with CONST_VAL).
module mux_sel_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W = 3,
  parameter int CONST_IDX = 1,
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(DEFAULT_CONST_VAL)
) (
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        selector,
  output logic [WIDTH-1:0]        word,
  output logic                    out_of_range
);

`ifdef MUX_CONST_EN
  localparam bit CONST_EN = 1'b1;
`else
  localparam bit CONST_EN = 1'b0;
`endif

  logic [31:0] sel_ext;

  assign sel_ext = {{(32-SEL_W){1'b0}}, selector};

  // Out-of-range codes fall back to channel 0 and are flagged for the error counter.
  always_comb begin
    word = data_in[WIDTH-1:0];
    out_of_range = (sel_ext >= NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_ext == k) begin
        word = data_in[k*WIDTH +: WIDTH];
      end
    end
    if (CONST_EN && (sel_ext == CONST_IDX)) begin
      word = CONST_VAL;
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered operand mux with a 2-entry skid buffer and out-of-range error counter.
// Optional feature macro: MUX_CONST_EN (constant word on channel CONST_IDX).
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W = 3,
  parameter int CONST_IDX = 1,
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(DEFAULT_CONST_VAL)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        selector,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_count
);

  buf_state_t       state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;
  logic             accept;
  logic             deliver;

  mux_sel_core #(
    .WIDTH     (WIDTH),
    .NUM_IN    (NUM_IN),
    .SEL_W     (SEL_W),
    .CONST_IDX (CONST_IDX),
    .CONST_VAL (CONST_VAL)
  ) u_core (
    .data_in      (data_in),
    .selector     (selector),
    .word         (sel_word),
    .out_of_range (sel_bad)
  );

  assign in_ready  = !reset && (state != TWO);
  assign out_valid = (state != EMPTY);
  assign data_out  = head;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  // Skid buffer: the head is always the oldest word, skid only fills on a stalled accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            head  <= sel_word;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            head <= sel_word;
          end else if (accept) begin
            skid  <= sel_word;
            state <= TWO;
          end else if (deliver) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (deliver) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // A fresh error accept takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else if (accept && sel_bad) begin
      sel_err <= 1'b1;
      if (err_clr) begin
        err_count <= ERR_CNT_W'(1);
      end else if (err_count != {ERR_CNT_W{1'b1}}) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end else if (err_clr) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed self-checking bench for mux_sel_pipe (default or MUX_CONST_EN build).
module tb_mux_sel_pipe;

  localparam int WIDTH = 32;
  localparam int NUM_IN = 5;
  localparam int SEL_W = 3;

  logic                    clk;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]        selector;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        data_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_clr;
  logic                    sel_err;
  logic [7:0]              err_count;

  int errors = 0;
  int checks = 0;

  mux_sel_pipe #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .selector  (selector),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .sel_err   (sel_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] val);
    data_in[k*WIDTH +: WIDTH] = val;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    selector = '0; data_in = '0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 00000000", data_out); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (sel_err !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_err: got %b/%0d expected 0/0", sel_err, err_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [SEL_W-1:0] sels [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
    logic [WIDTH-1:0] exp;
    for (int k = 0; k < NUM_IN; k++) set_ch(k, 32'hA000_0000 + 32'(k) * 32'h111);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      selector = sels[i];
      in_valid = 1'b1;
      exp = 32'hA000_0000 + 32'(sels[i]) * 32'h111;
      tick();
      checks++;
      if (out_valid !== 1'b1 || data_out !== exp) begin
        errors++; $display("[TB] FAIL basic_sel%0d: got v=%b d=%h expected v=1 d=%h", sels[i], out_valid, data_out, exp);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain: got %b expected 0", out_valid); end
    checks++;
    if (sel_err !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("[TB] FAIL basic_no_err: got %b/%0d expected 0/0", sel_err, err_count);
    end
  endtask

  task automatic test_const();
    logic [WIDTH-1:0] exp;
`ifdef MUX_CONST_EN
    exp = 32'h0000_0004;
`else
    exp = 32'h0000_DEAD;
`endif
    set_ch(1, 32'h0000_DEAD);
    selector = 3'd1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (data_out !== exp) begin errors++; $display("[TB] FAIL const_slot: got %h expected %h", data_out, exp); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; selector = 3'd2;
    set_ch(2, 32'h1111_AAAA);
    tick();
    checks++;
    if (in_ready !== 1'b1 || data_out !== 32'h1111_AAAA) begin
      errors++; $display("[TB] FAIL stall_c1: got r=%b d=%h expected r=1 d=1111aaaa", in_ready, data_out);
    end
    set_ch(2, 32'h2222_BBBB);
    tick();
    checks++;
    if (in_ready !== 1'b0 || data_out !== 32'h1111_AAAA) begin
      errors++; $display("[TB] FAIL stall_c2: got r=%b d=%h expected r=0 d=1111aaaa", in_ready, data_out);
    end
    set_ch(2, 32'h3333_CCCC);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== 32'h1111_AAAA) begin
      errors++; $display("[TB] FAIL stall_c3: got r=%b v=%b d=%h expected r=0 v=1 d=1111aaaa", in_ready, out_valid, data_out);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || data_out !== 32'h2222_BBBB || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL release_2nd: got v=%b d=%h r=%b expected v=1 d=2222bbbb r=1", out_valid, data_out, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_errors();
    logic [SEL_W-1:0] bad [3] = '{3'd5, 3'd6, 3'd7};
    set_ch(0, 32'hC0C0_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      selector = bad[i]; in_valid = 1'b1;
      tick();
      checks++;
      if (data_out !== 32'hC0C0_0000) begin
        errors++; $display("[TB] FAIL err_sel%0d_data: got %h expected c0c00000", bad[i], data_out);
      end
    end
    checks++;
    if (sel_err !== 1'b1 || err_count !== 8'd3) begin
      errors++; $display("[TB] FAIL err_count3: got %b/%0d expected 1/3", sel_err, err_count);
    end
    selector = 3'd7;
    for (int i = 0; i < 260; i++) tick();
    checks++;
    if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL err_saturate: got %0d expected 255", err_count); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    selector = 3'd6; in_valid = 1'b1; err_clr = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (sel_err !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("[TB] FAIL clr_with_err: got %b/%0d expected 1/1", sel_err, err_count);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (sel_err !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("[TB] FAIL clr_alone: got %b/%0d expected 0/0", sel_err, err_count);
    end
    err_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_two();
    out_ready = 1'b0; in_valid = 1'b1; selector = 3'd5;
    tick();
    selector = 3'd3;
    tick();
    checks++;
    if (in_ready !== 1'b0 || err_count !== 8'd1) begin
      errors++; $display("[TB] FAIL pre_reset_two: got r=%b cnt=%0d expected r=0 cnt=1", in_ready, err_count);
    end
    reset = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || data_out !== 32'h0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_two: got v=%b d=%h cnt=%0d r=%b expected v=0 d=0 cnt=0 r=0", out_valid, data_out, err_count, in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_hold: got r=%b v=%b expected r=0 v=0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_const();
    test_back_to_back();
    test_errors();
    test_clear();
    test_reset_in_two();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
